// File: rtl/fwvip_wb_core_pair.sv
// rtl/fwvip_wb_core_pair.sv - Wishbone classic initiator/target protocol-conversion pair
module fwvip_wb_core_pair #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int SEL_WIDTH = DATA_WIDTH / 8,
    localparam int REQ_WIDTH = ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH + 1,
    localparam int RSP_WIDTH = DATA_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    // initiator Wishbone master
    output logic [ADDR_WIDTH-1:0] i_adr,
    output logic [DATA_WIDTH-1:0] i_dat_w,
    output logic [SEL_WIDTH-1:0]  i_sel,
    output logic                  i_we,
    output logic                  i_cyc,
    output logic                  i_stb,
    input  logic [DATA_WIDTH-1:0] i_dat_r,
    input  logic                  i_ack,
    input  logic                  i_err,
    // initiator request / response
    input  logic [REQ_WIDTH-1:0]  ireq_dat,
    input  logic                  ireq_valid,
    output logic                  ireq_ready,
    output logic [RSP_WIDTH-1:0]  irsp_dat,
    output logic                  irsp_valid,
    input  logic                  irsp_ready,
    // target Wishbone slave
    input  logic [ADDR_WIDTH-1:0] t_adr,
    input  logic [DATA_WIDTH-1:0] t_dat_w,
    input  logic [SEL_WIDTH-1:0]  t_sel,
    input  logic                  t_we,
    input  logic                  t_cyc,
    input  logic                  t_stb,
    output logic [DATA_WIDTH-1:0] t_dat_r,
    output logic                  t_ack,
    output logic                  t_err,
    // target request / response
    output logic [REQ_WIDTH-1:0]  treq_dat,
    output logic                  treq_valid,
    input  logic                  treq_ready,
    input  logic [RSP_WIDTH-1:0]  trsp_dat,
    input  logic                  trsp_valid,
    output logic                  trsp_ready
);

    typedef enum logic [1:0] {I_IDLE, I_BUS, I_RSP} ist_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_RSP, T_ACK} tst_t;

    ist_t                  ist_q, ist_d;
    logic [ADDR_WIDTH-1:0] i_adr_q, i_adr_d;
    logic [DATA_WIDTH-1:0] i_dat_w_q, i_dat_w_d;
    logic [SEL_WIDTH-1:0]  i_sel_q, i_sel_d;
    logic                  i_we_q, i_we_d;
    logic                  i_cyc_q, i_cyc_d;
    logic [RSP_WIDTH-1:0]  irsp_dat_q, irsp_dat_d;
    logic                  irsp_valid_q, irsp_valid_d;

    tst_t                  tst_q, tst_d;
    logic [REQ_WIDTH-1:0]  treq_dat_q, treq_dat_d;
    logic                  treq_valid_q, treq_valid_d;
    logic [DATA_WIDTH-1:0] t_dat_r_q, t_dat_r_d;
    logic                  t_ack_q, t_ack_d;
    logic                  t_err_q, t_err_d;

    // Initiator state and registered master outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            ist_q        <= I_IDLE;
            i_adr_q      <= '0;
            i_dat_w_q    <= '0;
            i_sel_q      <= '0;
            i_we_q       <= 1'b0;
            i_cyc_q      <= 1'b0;
            irsp_dat_q   <= '0;
            irsp_valid_q <= 1'b0;
        end else begin
            ist_q        <= ist_d;
            i_adr_q      <= i_adr_d;
            i_dat_w_q    <= i_dat_w_d;
            i_sel_q      <= i_sel_d;
            i_we_q       <= i_we_d;
            i_cyc_q      <= i_cyc_d;
            irsp_dat_q   <= irsp_dat_d;
            irsp_valid_q <= irsp_valid_d;
        end
    end

    // Initiator next state: accept request, run one bus cycle, return response
    always_comb begin
        ist_d        = ist_q;
        i_adr_d      = i_adr_q;
        i_dat_w_d    = i_dat_w_q;
        i_sel_d      = i_sel_q;
        i_we_d       = i_we_q;
        i_cyc_d      = i_cyc_q;
        irsp_dat_d   = irsp_dat_q;
        irsp_valid_d = irsp_valid_q;
        ireq_ready   = 1'b0;
        case (ist_q)
            I_IDLE: begin
                ireq_ready = 1'b1;
                if (ireq_valid) begin
                    i_adr_d   = ireq_dat[REQ_WIDTH-1 -: ADDR_WIDTH];
                    i_dat_w_d = ireq_dat[SEL_WIDTH+1 +: DATA_WIDTH];
                    i_we_d    = ireq_dat[SEL_WIDTH];
                    i_sel_d   = ireq_dat[SEL_WIDTH-1:0];
                    i_cyc_d   = 1'b1;
                    ist_d     = I_BUS;
                end
            end
            I_BUS: begin
                if (i_ack || i_err) begin
                    i_cyc_d      = 1'b0;
                    irsp_dat_d   = {i_dat_r, i_err};
                    irsp_valid_d = 1'b1;
                    ist_d        = I_RSP;
                end
            end
            I_RSP: begin
                if (irsp_ready) begin
                    irsp_valid_d = 1'b0;
                    ist_d        = I_IDLE;
                end
            end
            default: ist_d = I_IDLE;
        endcase
    end

    // Target state and registered slave outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            tst_q        <= T_IDLE;
            treq_dat_q   <= '0;
            treq_valid_q <= 1'b0;
            t_dat_r_q    <= '0;
            t_ack_q      <= 1'b0;
            t_err_q      <= 1'b0;
        end else begin
            tst_q        <= tst_d;
            treq_dat_q   <= treq_dat_d;
            treq_valid_q <= treq_valid_d;
            t_dat_r_q    <= t_dat_r_d;
            t_ack_q      <= t_ack_d;
            t_err_q      <= t_err_d;
        end
    end

    // Target next state: capture bus cycle, wait for response, pulse ack/err once
    always_comb begin
        tst_d        = tst_q;
        treq_dat_d   = treq_dat_q;
        treq_valid_d = treq_valid_q;
        t_dat_r_d    = t_dat_r_q;
        t_ack_d      = t_ack_q;
        t_err_d      = t_err_q;
        trsp_ready   = 1'b0;
        case (tst_q)
            T_IDLE: begin
                if (t_cyc && t_stb) begin
                    treq_dat_d   = {t_adr, t_dat_w, t_we, t_sel};
                    treq_valid_d = 1'b1;
                    tst_d        = T_REQ;
                end
            end
            T_REQ: begin
                if (treq_ready) begin
                    treq_valid_d = 1'b0;
                    tst_d        = T_RSP;
                end
            end
            T_RSP: begin
                trsp_ready = 1'b1;
                if (trsp_valid) begin
                    t_dat_r_d = trsp_dat[RSP_WIDTH-1:1];
                    t_ack_d   = ~trsp_dat[0];
                    t_err_d   = trsp_dat[0];
                    tst_d     = T_ACK;
                end
            end
            T_ACK: begin
                t_ack_d = 1'b0;
                t_err_d = 1'b0;
                tst_d   = T_IDLE;
            end
            default: tst_d = T_IDLE;
        endcase
    end

    assign i_adr      = i_adr_q;
    assign i_dat_w    = i_dat_w_q;
    assign i_sel      = i_sel_q;
    assign i_we       = i_we_q;
    assign i_cyc      = i_cyc_q;
    assign i_stb      = i_cyc_q;
    assign irsp_dat   = irsp_dat_q;
    assign irsp_valid = irsp_valid_q;
    assign treq_dat   = treq_dat_q;
    assign treq_valid = treq_valid_q;
    assign t_dat_r    = t_dat_r_q;
    assign t_ack      = t_ack_q;
    assign t_err      = t_err_q;

endmodule

// File: tb/tb_fwvip_wb_core_pair.sv
// tb/tb_fwvip_wb_core_pair.sv - back-to-back bench with memory responder and transaction model
module tb_fwvip_wb_core_pair;
    localparam int AW = 32, DW = 32, SW = DW / 8, RQW = AW + DW + SW + 1, RSW = DW + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [AW-1:0]  bus_adr;
    logic [DW-1:0]  bus_dat_w, bus_dat_r;
    logic [SW-1:0]  bus_sel;
    logic           bus_we, bus_cyc, bus_stb, bus_ack, bus_err;
    logic [RQW-1:0] ireq_dat = '0;
    logic           ireq_valid = 1'b0;
    logic           ireq_ready;
    logic [RSW-1:0] irsp_dat;
    logic           irsp_valid;
    logic           irsp_ready = 1'b0;
    logic [RQW-1:0] treq_dat;
    logic           treq_valid;
    logic           treq_ready = 1'b0;
    logic [RSW-1:0] trsp_dat = '0;
    logic           trsp_valid = 1'b0;
    logic           trsp_ready;

    fwvip_wb_core_pair #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .i_adr(bus_adr), .i_dat_w(bus_dat_w), .i_sel(bus_sel), .i_we(bus_we),
        .i_cyc(bus_cyc), .i_stb(bus_stb), .i_dat_r(bus_dat_r), .i_ack(bus_ack), .i_err(bus_err),
        .ireq_dat(ireq_dat), .ireq_valid(ireq_valid), .ireq_ready(ireq_ready),
        .irsp_dat(irsp_dat), .irsp_valid(irsp_valid), .irsp_ready(irsp_ready),
        .t_adr(bus_adr), .t_dat_w(bus_dat_w), .t_sel(bus_sel), .t_we(bus_we),
        .t_cyc(bus_cyc), .t_stb(bus_stb), .t_dat_r(bus_dat_r), .t_ack(bus_ack), .t_err(bus_err),
        .treq_dat(treq_dat), .treq_valid(treq_valid), .treq_ready(treq_ready),
        .trsp_dat(trsp_dat), .trsp_valid(trsp_valid), .trsp_ready(trsp_ready)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RQW-1:0] mkreq(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input logic w, input logic [SW-1:0] s);
        return {a, d, w, s};
    endfunction

    // Transaction-level model: byte-addressed memory, error region at 0xE.......
    logic [7:0]     mbytes [logic [AW-1:0]];
    logic [RQW-1:0] send_q[$];
    logic [RQW-1:0] exp_treq_q[$];
    logic [RSW-1:0] exp_rsp_q[$];

    function automatic void model_submit(input logic [RQW-1:0] r);
        logic [AW-1:0] a;
        logic [DW-1:0] d, v;
        logic          w;
        logic [SW-1:0] s;
        a = r[RQW-1 -: AW];
        d = r[SW+1 +: DW];
        w = r[SW];
        s = r[SW-1:0];
        exp_treq_q.push_back(r);
        if (a[AW-1 -: 4] == 4'hE) begin
            exp_rsp_q.push_back({32'h0BAD0BAD, 1'b1});
        end else begin
            for (int b = 0; b < SW; b++) begin
                if (w && s[b]) mbytes[a + b] = d[8*b +: 8];
                v[8*b +: 8] = mbytes.exists(a + b) ? mbytes[a + b] : 8'h00;
            end
            exp_rsp_q.push_back({v, 1'b0});
        end
    endfunction

    // Environment responder: word memory fed from what the target presents
    logic [DW-1:0]  rmem [logic [AW-1:0]];
    bit             rand_mode = 0;
    bit             rsp_hold = 0;
    bit             pend_valid = 0;
    logic [RSW-1:0] pend_rsp = '0;
    int             pend_delay = 0;

    function automatic void respond(input logic [RQW-1:0] r);
        logic [AW-1:0] a;
        logic [DW-1:0] d, m, old;
        a = r[RQW-1 -: AW];
        d = r[SW+1 +: DW];
        for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{r[b]}};
        old = rmem.exists(a) ? rmem[a] : '0;
        if (a[AW-1 -: 4] == 4'hE) pend_rsp = {32'h0BAD0BAD, 1'b1};
        else if (r[SW]) begin
            rmem[a] = (old & ~m) | (d & m);
            pend_rsp = {rmem[a], 1'b0};
        end else pend_rsp = {old, 1'b0};
        pend_valid = 1;
        pend_delay = rand_mode ? int'($urandom_range(0, 3)) : 0;
    endfunction

    int             cyc_n = 0;
    int             rst_cnt = 5;
    bit             prev_rst = 1;
    int             treq_hold = 0, irsp_hold = 0;
    int             accept_cyc = 0;
    int             lat_log[$];
    logic [RSW-1:0] irsp_log[$];
    logic [RQW-1:0] treq_log[$];
    bit             err_pulse_seen = 0;
    bit             p_treq_stall = 0, p_irsp_stall = 0, p_cyc = 0, p_pulse = 0;
    logic [RQW-1:0] p_treq_dat = '0;
    logic [RSW-1:0] p_irsp_dat = '0;
    logic [AW+DW+SW:0] p_bus = '0;

    task automatic check_reset();
        chk("rst_i_adr", bus_adr, 0);
        chk("rst_i_dat_w", bus_dat_w, 0);
        chk("rst_i_sel", bus_sel, 0);
        chk("rst_i_we", bus_we, 0);
        chk("rst_i_cyc", bus_cyc, 0);
        chk("rst_i_stb", bus_stb, 0);
        chk("rst_irsp", {irsp_valid, irsp_dat}, 0);
        chk("rst_treq", {treq_valid, treq_dat}, 0);
        chk("rst_t_dat_r", bus_dat_r, 0);
        chk("rst_t_ack_err", {bus_ack, bus_err}, 0);
        chk("rst_ireq_ready", ireq_ready, 1);
        chk("rst_trsp_ready", trsp_ready, 0);
    endtask

    // Per-cycle compare and input drive, away from the active edge
    always @(negedge clock) begin
        cyc_n++;
        if (prev_rst) check_reset();
        else begin
            if (p_treq_stall) chk("treq_stall_stable", {treq_valid, treq_dat}, {1'b1, p_treq_dat});
            if (p_irsp_stall) chk("irsp_stall_stable", {irsp_valid, irsp_dat}, {1'b1, p_irsp_dat});
            if (p_cyc && bus_cyc) chk("bus_hold", {bus_adr, bus_dat_w, bus_sel, bus_we}, p_bus);
            chk("cyc_eq_stb", bus_stb, bus_cyc);
            chk("ack_err_excl", bus_ack & bus_err, 0);
            if (p_pulse) chk("ack_one_cycle", bus_ack | bus_err, 0);
            if (bus_err && !bus_ack) err_pulse_seen = 1;
        end
        if (rst_cnt > 0) begin
            rst_cnt--;
            reset = 1'b1;
            prev_rst = 1;
            ireq_valid = 1'b0;
            trsp_valid = 1'b0;
            treq_ready = 1'b0;
            irsp_ready = 1'b0;
            pend_valid = 0;
            send_q.delete();
            exp_treq_q.delete();
            exp_rsp_q.delete();
        end else begin
            reset = 1'b0;
            prev_rst = 0;
            trsp_valid = 1'b0;
            if (pend_valid) begin
                if (pend_delay > 0) pend_delay--;
                else if (!rsp_hold) begin
                    trsp_valid = 1'b1;
                    trsp_dat = pend_rsp;
                    if (trsp_ready) pend_valid = 0;
                end
            end
            if (treq_hold > 0 && treq_valid) begin
                treq_ready = 1'b0;
                treq_hold--;
            end else treq_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (treq_valid && treq_ready) begin
                treq_log.push_back(treq_dat);
                chk("treq_expected", exp_treq_q.size() != 0, 1);
                if (exp_treq_q.size() != 0) chk("treq_dat", treq_dat, exp_treq_q.pop_front());
                respond(treq_dat);
            end
            if (irsp_hold > 0 && irsp_valid) begin
                irsp_ready = 1'b0;
                irsp_hold--;
            end else irsp_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (irsp_valid && irsp_ready) begin
                irsp_log.push_back(irsp_dat);
                lat_log.push_back(cyc_n - accept_cyc);
                chk("irsp_expected", exp_rsp_q.size() != 0, 1);
                if (exp_rsp_q.size() != 0) chk("irsp_dat", irsp_dat, exp_rsp_q.pop_front());
            end
            if (send_q.size() != 0 && (ireq_valid || !rand_mode || $urandom_range(0, 3) != 0)) begin
                ireq_valid = 1'b1;
                ireq_dat = send_q[0];
            end else ireq_valid = 1'b0;
            if (ireq_valid && ireq_ready) begin
                void'(send_q.pop_front());
                model_submit(ireq_dat);
                accept_cyc = cyc_n;
            end
        end
        p_treq_stall = !reset && treq_valid && !treq_ready;
        p_treq_dat = treq_dat;
        p_irsp_stall = !reset && irsp_valid && !irsp_ready;
        p_irsp_dat = irsp_dat;
        p_cyc = !reset && bus_cyc;
        p_bus = {bus_adr, bus_dat_w, bus_sel, bus_we};
        p_pulse = !reset && (bus_ack | bus_err);
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((send_q.size() != 0 || exp_rsp_q.size() != 0 || pend_valid) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("wait_idle_timeout", n < budget, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        irsp_log.delete();
        treq_log.delete();
        lat_log.delete();
    endtask

    initial begin
        logic [DW-1:0] wdat[3];
        logic [AW-1:0] a;
        logic          w;
        int            n;
        wdat[0] = 32'hA5A50000;
        wdat[1] = 32'h5A5A1111;
        wdat[2] = 32'hDEADBEEF;
        repeat (7) @(posedge clock);
        #1;

        // writes then reads
        for (int i = 0; i < 3; i++) send_q.push_back(mkreq(AW'(4 * i), wdat[i], 1'b1, 4'hF));
        for (int i = 0; i < 3; i++) send_q.push_back(mkreq(AW'(4 * i), '0, 1'b0, 4'hF));
        wait_idle(500);
        chk("rsp_count6", irsp_log.size(), 6);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rsp_lit", irsp_log[i], {wdat[i], 1'b0});
            chk("rd_rsp_lit", irsp_log[i+3], {wdat[i], 1'b0});
        end
        chk("treq0_lit", treq_log[0], {32'h0, 32'hA5A50000, 1'b1, 4'hF});
        chk("first_latency", lat_log[0], 5);

        // error response
        clear_logs();
        err_pulse_seen = 0;
        send_q.push_back(mkreq(32'hE0000010, 32'h11112222, 1'b1, 4'hF));
        wait_idle(500);
        chk("err_rsp_lit", irsp_log[0], {32'h0BAD0BAD, 1'b1});
        chk("err_pulse", err_pulse_seen, 1);

        // stalls on treq_ready and irsp_ready
        clear_logs();
        treq_hold = 5;
        irsp_hold = 3;
        send_q.push_back(mkreq(32'h4, '0, 1'b0, 4'hF));
        wait_idle(500);
        chk("stall_rsp_count", irsp_log.size(), 1);
        chk("stall_treq_count", treq_log.size(), 1);
        chk("stall_rsp_lit", irsp_log[0], {32'h5A5A1111, 1'b0});
        chk("stall_latency", lat_log[0], 13);

        // reset while initiator in I_BUS and target in T_RSP
        clear_logs();
        rsp_hold = 1;
        send_q.push_back(mkreq(32'h8, '0, 1'b0, 4'hF));
        n = 0;
        while (!(trsp_ready && bus_cyc) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("reach_bus_rsp", n < 100, 1);
        rst_cnt = 1;
        repeat (3) @(posedge clock);
        #1;
        rsp_hold = 0;
        chk("abort_no_rsp", irsp_log.size(), 0);
        send_q.push_back(mkreq(32'hC, 32'h12345678, 1'b1, 4'hF));
        wait_idle(500);
        chk("post_reset_rsp", irsp_log.size() == 1 ? irsp_log[0] : '1, {32'h12345678, 1'b0});

        // randomized traffic with random stalls and responder delay
        rand_mode = 1;
        for (int i = 0; i < 60; i++) begin
            a = AW'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 9) == 0) a = a | 32'hE0000000;
            w = 1'($urandom_range(0, 1));
            send_q.push_back(mkreq(a, DW'($urandom), w, w ? SW'($urandom_range(1, 15)) : 4'hF));
        end
        wait_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
